// File: rtl/isa_track_pkg.sv
// Shared types and constants for the RV12 shadow pipeline tracker.
// Opcode/funct3 constants, stage and golden-result bundles, ALU helper.
package isa_track_pkg;

    // Data/PC width of the bundles below; the top's XLEN must match.
    localparam int XW = 32;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [31:0]   insn;
        logic          valid;
    } stage_t;

    typedef struct packed {
        logic          covered;
        logic          we;
        logic [4:0]    rd;
        logic [XW-1:0] data;
    } golden_t;

    // alt selects SUB for ADD and arithmetic shift for SR.
    function automatic logic [XW-1:0] alu_f(
        input logic [2:0]    f3,
        input logic          alt,
        input logic [XW-1:0] a,
        input logic [XW-1:0] b
    );
        logic [XW-1:0] r;
        r = '0;
        unique case (f3)
            F3_ADD:  r = alt ? a - b : a + b;
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {{(XW-1){1'b0}}, $signed(a) < $signed(b)};
            F3_SLTU: r = {{(XW-1){1'b0}}, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = alt ? XW'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:   r = a | b;
            F3_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/isa_track_golden.sv
// Combinational golden model: decodes a retiring instruction and computes
// its expected register write. Ports: insn_i, pc_i, rs1_i, rs2_i (only with
// ISA_TRACK_RTYPE_EN) -> gold_o {covered, we, rd, data}.
module isa_track_golden
    import isa_track_pkg::*;
(
    input  logic [31:0]   insn_i,
    input  logic [XW-1:0] pc_i,
    input  logic [XW-1:0] rs1_i,
`ifdef ISA_TRACK_RTYPE_EN
    input  logic [XW-1:0] rs2_i,
`endif
    output golden_t       gold_o
);

    logic [6:0]    opc;
    logic [2:0]    f3;
    logic [XW-1:0] imm_i;
    logic [XW-1:0] imm_u;

    assign opc   = insn_i[6:0];
    assign f3    = insn_i[14:12];
    assign imm_i = {{(XW-12){insn_i[31]}}, insn_i[31:20]};
    assign imm_u = {insn_i[31:12], 12'b0};

`ifdef ISA_TRACK_RTYPE_EN
    logic is_op;
    assign is_op = (opc == OPC_OP) &&
                   ((insn_i[31:25] == 7'b0000000) ||
                    ((insn_i[31:25] == 7'b0100000) &&
                     ((f3 == F3_ADD) || (f3 == F3_SR))));
`endif

    always_comb begin
        gold_o    = '0;
        gold_o.rd = insn_i[11:7];
        unique case (1'b1)
            (opc == OPC_OPIMM): begin
                gold_o.covered = 1'b1;
                // insn[30] only matters for SRAI; ADDI has no subtract form
                gold_o.data = alu_f(f3, (f3 == F3_SR) && insn_i[30],
                                    rs1_i, imm_i);
            end
            (opc == OPC_LUI): begin
                gold_o.covered = 1'b1;
                gold_o.data    = imm_u;
            end
            (opc == OPC_AUIPC): begin
                gold_o.covered = 1'b1;
                gold_o.data    = pc_i + imm_u;
            end
`ifdef ISA_TRACK_RTYPE_EN
            is_op: begin
                gold_o.covered = 1'b1;
                gold_o.data    = alu_f(f3, insn_i[30], rs1_i, rs2_i);
            end
`endif
            default: ;
        endcase
        gold_o.we = gold_o.covered && (gold_o.rd != 5'd0);
    end

endmodule

// File: rtl/isa_pipe_tracker.sv
// Shadow pipeline follower: tracks PC/insn/bubble per stage with stall and
// flush, emits a registered retire record and checks DUT writeback against
// a golden model. Ports: clk, rst_n, if_*_i (fetch), stall_i/flush_i,
// dut_wb_*_i (DUT writeback), stage_valid_o, ret_*_o, chk_*_o, err_*_o.
// Optional: define ISA_TRACK_RTYPE_EN to also check OP (R-type) ops.
module isa_pipe_tracker
    import isa_track_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     STAGES   = 5,
    parameter logic [XLEN-1:0] PC_INIT  = 32'h200,
    parameter logic [31:0]     NOP_INSN = 32'h13,
    parameter int unsigned     CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    input  logic [XLEN-1:0]   if_pc_i,
    input  logic [31:0]       if_insn_i,
    input  logic [STAGES-1:0] stall_i,
    input  logic [STAGES-1:0] flush_i,
    input  logic              dut_wb_we_i,
    input  logic [4:0]        dut_wb_dst_i,
    input  logic [XLEN-1:0]   dut_wb_data_i,
    output logic [STAGES-1:0] stage_valid_o,
    output logic              ret_valid_o,
    output logic [XLEN-1:0]   ret_pc_o,
    output logic [31:0]       ret_insn_o,
    output logic              chk_valid_o,
    output logic              chk_err_o,
    output logic              err_sticky_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int L = STAGES - 1;

    stage_t            stg_q [STAGES];
    stage_t            stg_d [STAGES];
    logic [STAGES-1:0] hold;

    logic              ret_valid_q;
    logic [XLEN-1:0]   ret_pc_q;
    logic [31:0]       ret_insn_q;
    logic              chk_valid_q, chk_valid_d;
    logic              chk_err_q, chk_err_d;
    logic              sticky_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rf_q [32];

    golden_t           gold;
    logic              mism;

    // A stall in stage s also freezes everything upstream of it.
    always_comb begin
        hold = '0;
        for (int s = 0; s < STAGES; s++)
            hold[s] = |(stall_i >> s);
    end

    always_comb begin
        stg_d[0].pc    = {if_pc_i[XLEN-1:2], 2'b00};
        stg_d[0].insn  = if_insn_i;
        stg_d[0].valid = if_valid_i;
        for (int s = 1; s < STAGES; s++) begin
            stg_d[s] = stg_q[s-1];
            // Upstream held or killed while we advance: take a bubble.
            stg_d[s].valid = stg_q[s-1].valid & ~hold[s-1] & ~flush_i[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stg_q[s].pc    <= PC_INIT;
                stg_q[s].insn  <= NOP_INSN;
                stg_q[s].valid <= 1'b0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (!hold[s])
                    stg_q[s] <= stg_d[s];
                if (flush_i[s])
                    stg_q[s].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        stage_valid_o = '0;
        for (int s = 0; s < STAGES; s++)
            stage_valid_o[s] = stg_q[s].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_valid_q <= 1'b0;
            ret_pc_q    <= PC_INIT;
            ret_insn_q  <= NOP_INSN;
        end else begin
            ret_valid_q <= stg_q[L].valid & ~stall_i[L] & ~flush_i[L];
            if (!stall_i[L]) begin
                ret_pc_q   <= stg_q[L].pc;
                ret_insn_q <= stg_q[L].insn;
            end
        end
    end

    isa_track_golden u_golden (
        .insn_i (ret_insn_q),
        .pc_i   (ret_pc_q),
        .rs1_i  (rf_q[ret_insn_q[19:15]]),
`ifdef ISA_TRACK_RTYPE_EN
        .rs2_i  (rf_q[ret_insn_q[24:20]]),
`endif
        .gold_o (gold)
    );

    always_comb begin
        mism = (dut_wb_we_i != gold.we) ||
               (gold.we && ((dut_wb_dst_i != gold.rd) ||
                            (dut_wb_data_i != gold.data)));
        chk_valid_d = ret_valid_q & gold.covered;
        chk_err_d   = (chk_valid_d & mism) | (dut_wb_we_i & ~ret_valid_q);
    end

    // Shadow file mirrors the DUT so one bad write does not cascade.
    // Entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++)
                rf_q[r] <= '0;
        end else if (dut_wb_we_i && (dut_wb_dst_i != 5'd0)) begin
            rf_q[dut_wb_dst_i] <= dut_wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            chk_valid_q <= chk_valid_d;
            chk_err_q   <= chk_err_d;
            if (chk_err_d) begin
                sticky_q <= 1'b1;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ret_valid_o  = ret_valid_q;
    assign ret_pc_o     = ret_pc_q;
    assign ret_insn_o   = ret_insn_q;
    assign chk_valid_o  = chk_valid_q;
    assign chk_err_o    = chk_err_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_isa_pipe_tracker.sv
// Directed bench for isa_pipe_tracker: vector table for the golden model,
// plus stall, flush, spurious write, saturation and async reset sequences.
module tb_isa_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_insn_i;
    logic [4:0]  stall_i;
    logic [4:0]  flush_i;
    logic        dut_wb_we_i;
    logic [4:0]  dut_wb_dst_i;
    logic [31:0] dut_wb_data_i;
    logic [4:0]  stage_valid_o;
    logic        ret_valid_o;
    logic [31:0] ret_pc_o;
    logic [31:0] ret_insn_o;
    logic        chk_valid_o;
    logic        chk_err_o;
    logic        err_sticky_o;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    isa_pipe_tracker #(
        .XLEN(32), .STAGES(5), .PC_INIT(32'h200),
        .NOP_INSN(32'h13), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_insn_i(if_insn_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .dut_wb_we_i(dut_wb_we_i), .dut_wb_dst_i(dut_wb_dst_i),
        .dut_wb_data_i(dut_wb_data_i),
        .stage_valid_o(stage_valid_o), .ret_valid_o(ret_valid_o),
        .ret_pc_o(ret_pc_o), .ret_insn_o(ret_insn_o),
        .chk_valid_o(chk_valid_o), .chk_err_o(chk_err_o),
        .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o)
    );

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] exp_pc;
        logic        exp_cv;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input string nm, input logic [31:0] insn,
                        input logic [31:0] pc, input logic we,
                        input logic [4:0] dst, input logic [31:0] data,
                        input logic [31:0] exp_pc, input logic cv,
                        input logic err);
        vec_t v;
        v.name = nm; v.insn = insn; v.pc = pc; v.we = we; v.dst = dst;
        v.data = data; v.exp_pc = exp_pc; v.exp_cv = cv; v.exp_err = err;
        tbl.push_back(v);
    endtask

    // Fetch one instruction into an empty pipe, wait for retirement,
    // present the DUT writeback in that cycle, check the result next cycle.
    task automatic run_vec(input vec_t v);
        int k;
        bit seen;
        if_valid_i = 1'b1; if_pc_i = v.pc; if_insn_i = v.insn;
        step();
        if_valid_i = 1'b0; if_insn_i = 32'h13;
        k = 0; seen = 1'b0;
        while (!seen && k < 12) begin
            step();
            k++;
            seen = ret_valid_o;
        end
        chk({v.name, "_lat"}, k, 5);
        chk({v.name, "_pc"}, ret_pc_o, v.exp_pc);
        chk({v.name, "_insn"}, ret_insn_o, v.insn);
        dut_wb_we_i = v.we; dut_wb_dst_i = v.dst; dut_wb_data_i = v.data;
        step();
        dut_wb_we_i = 1'b0;
        chk({v.name, "_cv"}, chk_valid_o, v.exp_cv);
        chk({v.name, "_err"}, chk_err_o, v.exp_err);
    endtask

    logic [31:0] r_pc[$];
    int          r_edge[$];
    int          fi;
    logic        rtype_cv;

    initial begin
`ifdef ISA_TRACK_RTYPE_EN
        rtype_cv = 1'b1;
`else
        rtype_cv = 1'b0;
`endif
        addv("addi_x5",   32'h00700293, 32'h204, 1, 5,  32'h7,        32'h204,  1, 0);
        addv("addi_neg",  32'hFF000093, 32'h20B, 1, 1,  32'hFFFFFFF0, 32'h208,  1, 0);
        addv("srai_bad",  32'h4020D113, 32'h20C, 1, 2,  32'h3FFFFFFC, 32'h20C,  1, 1);
        addv("shadow_x2", 32'h00010213, 32'h210, 1, 4,  32'h3FFFFFFC, 32'h210,  1, 0);
        addv("auipc_wrap",32'hFFFFF197, 32'h1000,1, 3,  32'h0,        32'h1000, 1, 0);
        addv("addi_x0",   32'h00100013, 32'h1004,0, 0,  32'h0,        32'h1004, 1, 0);
        addv("lui",       32'h123453B7, 32'h1008,1, 7,  32'h12345000, 32'h1008, 1, 0);
        addv("sltiu",     32'h0010B413, 32'h100C,1, 8,  32'h0,        32'h100C, 1, 0);
        addv("slti",      32'h0010A493, 32'h1010,1, 9,  32'h1,        32'h1010, 1, 0);
        addv("add_op",    32'h00508533, 32'h1014,1, 10, 32'hFFFFFFF7, 32'h1014, rtype_cv, 0);
        addv("bad_rd",    32'h00300593, 32'h1018,1, 12, 32'h3,        32'h1018, 1, 1);
        addv("xori",      32'hFFF2C693, 32'h101C,1, 13, 32'hFFFFFFF8, 32'h101C, 1, 0);
        addv("srli",      32'h0040D713, 32'h1020,1, 14, 32'h0FFFFFFF, 32'h1020, 1, 0);

        rst_n = 1'b0; if_valid_i = 1'b0; if_pc_i = '0; if_insn_i = 32'h13;
        stall_i = '0; flush_i = '0;
        dut_wb_we_i = 1'b0; dut_wb_dst_i = '0; dut_wb_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sv", stage_valid_o, 5'b0);
        chk("rst_rv", ret_valid_o, 0);
        chk("rst_pc", ret_pc_o, 32'h200);
        chk("rst_insn", ret_insn_o, 32'h13);
        chk("rst_cnt", {err_sticky_o, err_cnt_o, chk_err_o, chk_valid_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) run_vec(tbl[i]);
        chk("tbl_cnt", err_cnt_o, 2);
        chk("tbl_sticky", err_sticky_o, 1);

        // Stall stage 2 for two edges; uncovered store opcode in flight.
        fi = 0;
        for (int e = 0; e < 16; e++) begin
            stall_i    = (e == 4 || e == 5) ? 5'b00100 : 5'b00000;
            if_valid_i = (fi < 6);
            if_pc_i    = 32'h300 + 32'(4 * fi);
            if_insn_i  = 32'h00000023;
            step();
            if (stall_i == 5'b0 && fi < 6) fi++;
            if (e == 4) chk("stall_bubble", stage_valid_o, 5'b10111);
            if (ret_valid_o) begin
                r_pc.push_back(ret_pc_o);
                r_edge.push_back(e);
            end
        end
        stall_i = '0; if_valid_i = 1'b0;
        chk("stall_n", r_pc.size(), 6);
        for (int i = 0; i < 6 && i < r_pc.size(); i++) begin
            chk($sformatf("stall_pc%0d", i), r_pc[i], 32'h300 + 32'(4 * i));
            chk($sformatf("stall_edge%0d", i), r_edge[i], (i == 0) ? 5 : 7 + i);
        end

        // Kill the instruction in stage 1 while stalling it as well.
        r_pc.delete();
        r_edge.delete();
        fi = 0;
        for (int e = 0; e < 14; e++) begin
            stall_i    = (e == 2) ? 5'b00010 : 5'b00000;
            flush_i    = (e == 2) ? 5'b00010 : 5'b00000;
            if_valid_i = (fi < 5);
            if_pc_i    = 32'h400 + 32'(4 * fi);
            if_insn_i  = 32'h00000023;
            step();
            if (stall_i == 5'b0 && fi < 5) fi++;
            if (ret_valid_o) r_pc.push_back(ret_pc_o);
        end
        stall_i = '0; flush_i = '0; if_valid_i = 1'b0;
        chk("flush_n", r_pc.size(), 4);
        for (int i = 0; i < 4 && i < r_pc.size(); i++)
            chk($sformatf("flush_pc%0d", i), r_pc[i], 32'h404 + 32'(4 * i));

        // Write with nothing retiring.
        dut_wb_we_i = 1'b1; dut_wb_dst_i = 5'd20; dut_wb_data_i = 32'h55;
        step();
        chk("spur_err", chk_err_o, 1);
        chk("spur_cv", chk_valid_o, 0);
        chk("spur_cnt", err_cnt_o, 3);

        dut_wb_dst_i = 5'd0;
        repeat (300) step();
        chk("sat_cnt", err_cnt_o, 255);
        chk("sat_sticky", err_sticky_o, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", err_cnt_o, 0);
        chk("arst_sticky", err_sticky_o, 0);
        chk("arst_err", chk_err_o, 0);
        chk("arst_pc", ret_pc_o, 32'h200);
        dut_wb_we_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_cnt", err_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
